// File: rtl/mac_pkg.sv
// Shared constants and helpers for the vector multiply-accumulate engine.
package mac_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_LANES  = 4;

  // Widest packed operand vector the lane-select helper can address.
  localparam int MAX_VEC_W = 1024;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Largest signed value representable in 'width' bits.
  function automatic longint sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Smallest signed value representable in 'width' bits.
  function automatic longint sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  // Extracts lane 'idx' of 'width' bits from a packed vector, sign-extended.
  function automatic longint lane_sel(input logic [MAX_VEC_W-1:0] vec,
                                      input int idx, input int width);
    logic [63:0] raw;
    longint      tmp;
    raw = vec[idx*width +: 64];
    tmp = longint'(raw << (64 - width));
    return tmp >>> (64 - width);
  endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// Combinational signed reduction of a packed product vector.
module mac_adder_tree
  import mac_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int IN_W  = 2 * DEF_DATA_W,
  parameter int OUT_W = 2 * DEF_DATA_W + clog2(DEF_LANES)
) (
  input  logic [LANES*IN_W-1:0] vec_i,
  output logic signed [OUT_W-1:0] sum_o
);

  logic signed [OUT_W-1:0] node [LANES];

  // Pairwise tree: each level folds node[i+step] into node[i].
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      node[i] = OUT_W'($signed(vec_i[i*IN_W +: IN_W]));
    end
    for (int step = 1; step < LANES; step = step * 2) begin
      for (int i = 0; i < LANES; i = i + 2 * step) begin
        node[i] = node[i] + node[i+step];
      end
    end
    sum_o = node[0];
  end

endmodule

// File: rtl/mac_vec.sv
// Pipelined vector multiply-accumulate: S1 registers lane products,
// S2 reduces them into the accumulator and emits one result per vector.
module mac_vec
  import mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LANES  = DEF_LANES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    sat_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_acc,
  output logic                    out_ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int TREE_W = 2 * DATA_W + clog2(LANES);
  localparam int SUM_W  = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

  logic                      stall;
  logic                      accept;
  logic [LANES*PROD_W-1:0]   prod_d;

  logic                      s1_valid_q;
  logic                      s1_last_q;
  logic                      s1_sat_q;
  logic [LANES*PROD_W-1:0]   s1_prod_q;

  logic signed [ACC_W-1:0]   acc_q;
  logic                      sticky_q;
  logic                      first_q;
  logic                      out_valid_q;
  logic [ACC_W-1:0]          out_acc_q;
  logic                      out_ovf_q;

  logic signed [TREE_W-1:0]  tree_sum;
  logic signed [SUM_W-1:0]   sum_ext;
  logic signed [SUM_W-1:0]   base;
  logic signed [SUM_W-1:0]   next_sum;
  logic signed [ACC_W-1:0]   acc_d;
  logic                      beat_ovf;

  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = !stall;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DATA_W-1:0] a_lane;
    logic signed [DATA_W-1:0] b_lane;
    assign a_lane = DATA_W'(lane_sel(MAX_VEC_W'(in_a), i, DATA_W));
    assign b_lane = DATA_W'(lane_sel(MAX_VEC_W'(in_b), i, DATA_W));
    assign prod_d[i*PROD_W +: PROD_W] = PROD_W'(a_lane) * PROD_W'(b_lane);
  end

  // S1: capture full-precision products of an accepted beat; hold on stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sat_q   <= 1'b0;
      s1_prod_q  <= '0;
    end else if (clear) begin
      s1_valid_q <= 1'b0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_last_q <= in_last;
        s1_sat_q  <= sat_en;
        s1_prod_q <= prod_d;
      end
    end
  end

  mac_adder_tree #(
    .LANES (LANES),
    .IN_W  (PROD_W),
    .OUT_W (TREE_W)
  ) u_tree (
    .vec_i (s1_prod_q),
    .sum_o (tree_sum)
  );

  // S2 arithmetic: add beat sum to the running total, detect and resolve overflow.
  always_comb begin
    sum_ext  = SUM_W'(tree_sum);
    base     = first_q ? '0 : SUM_W'(acc_q);
    next_sum = base + sum_ext;
    beat_ovf = next_sum[ACC_W] ^ next_sum[ACC_W-1];
    acc_d    = next_sum[ACC_W-1:0];
    if (beat_ovf && s1_sat_q) begin
      acc_d = next_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // S2 state: accumulate mid-vector beats, publish the result on the last beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else if (clear) begin
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= 1'b0;
      if (s1_valid_q) begin
        if (s1_last_q) begin
          out_acc_q   <= acc_d;
          out_ovf_q   <= sticky_q | beat_ovf;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
          sticky_q    <= 1'b0;
          first_q     <= 1'b1;
        end else begin
          acc_q    <= acc_d;
          sticky_q <= sticky_q | beat_ovf;
          first_q  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_vec.sv
// Directed bench for mac_vec: a 32-bit accumulator instance for the main
// scenarios and a 20-bit instance sharing the same inputs for overflow cases.
module tb_mac_vec;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        sat_en;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_acc;
  logic        out_ovf;

  logic        in_ready20;
  logic        out_valid20;
  logic [19:0] out_acc20;
  logic        out_ovf20;

  int nVec;
  int nMiss;

  mac_vec #(.DATA_W(8), .ACC_W(32), .LANES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .sat_en    (sat_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf)
  );

  mac_vec #(.DATA_W(8), .ACC_W(20), .LANES(4)) dut20 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .sat_en    (sat_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready20),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid20),
    .out_ready (out_ready),
    .out_acc   (out_acc20),
    .out_ovf   (out_ovf20)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane 0 goes in the low byte.
  function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(l0);
    b1 = 8'(l1);
    b2 = 8'(l2);
    b3 = 8'(l3);
    return {b3, b2, b1, b0};
  endfunction

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic driveBeat(input logic [31:0] a, input logic [31:0] b, input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
  endtask

  task automatic driveIdle();
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_last  = 1'b0;
  endtask

  // Reset state of both instances.
  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    nVec++;
    if (out_valid !== 1'b0 || out_acc !== 32'd0 || out_ovf !== 1'b0) begin
      nMiss++;
      $display("[TB] FAIL reset_state: got valid=%b acc=%0d ovf=%b want 0 0 0", out_valid, $signed(out_acc), out_ovf);
    end
    rst_n = 1'b1;
    step();
    nVec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nMiss++;
      $display("[TB] FAIL reset_ready: got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    nVec++;
    if (out_valid20 !== 1'b0 || out_acc20 !== 20'd0) begin
      nMiss++;
      $display("[TB] FAIL reset_state20: got valid=%b acc=%0d want 0 0", out_valid20, $signed(out_acc20));
    end
  endtask

  // One-beat vector and its two-cycle latency.
  task automatic test_single();
    driveBeat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1);
    step();
    driveIdle();
    nVec++;
    if (out_valid !== 1'b0) begin
      nMiss++;
      $display("[TB] FAIL single_early: got valid=%b want 0", out_valid);
    end
    step();
    nVec++;
    if (out_valid !== 1'b1 || out_acc !== 32'd70 || out_ovf !== 1'b0) begin
      nMiss++;
      $display("[TB] FAIL single_result: got valid=%b acc=%0d ovf=%b want 1 70 0", out_valid, $signed(out_acc), out_ovf);
    end
    step();
    nVec++;
    if (out_valid !== 1'b0) begin
      nMiss++;
      $display("[TB] FAIL single_drop: got valid=%b want 0", out_valid);
    end
  endtask

  // Two-beat vector followed immediately by a one-beat vector.
  task automatic test_back_to_back();
    driveBeat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b0);
    step();
    driveBeat(pack4(-1, -1, -1, -1), pack4(10, 10, 10, 10), 1'b1);
    step();
    nVec++;
    if (out_valid !== 1'b0) begin
      nMiss++;
      $display("[TB] FAIL b2b_mid: got valid=%b want 0", out_valid);
    end
    driveBeat(pack4(2, 0, 0, 0), pack4(3, 0, 0, 0), 1'b1);
    step();
    driveIdle();
    nVec++;
    if (out_valid !== 1'b1 || out_acc !== 32'd30 || out_ovf !== 1'b0) begin
      nMiss++;
      $display("[TB] FAIL b2b_first: got valid=%b acc=%0d ovf=%b want 1 30 0", out_valid, $signed(out_acc), out_ovf);
    end
    step();
    nVec++;
    if (out_valid !== 1'b1 || out_acc !== 32'd6) begin
      nMiss++;
      $display("[TB] FAIL b2b_second: got valid=%b acc=%0d want 1 6", out_valid, $signed(out_acc));
    end
    step();
    nVec++;
    if (out_valid !== 1'b0) begin
      nMiss++;
      $display("[TB] FAIL b2b_drop: got valid=%b want 0", out_valid);
    end
  endtask

  // Eight beats of 65536 overflow a 20-bit accumulator by exactly one.
  task automatic test_overflow(input logic sat);
    logic [19:0] want20;
    want20 = sat ? 20'h7FFFF : 20'h80000;
    sat_en = sat;
    for (int k = 0; k < 8; k++) begin
      driveBeat(pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), k == 7);
      step();
    end
    driveIdle();
    step();
    nVec++;
    if (out_valid20 !== 1'b1 || out_acc20 !== want20 || out_ovf20 !== 1'b1) begin
      nMiss++;
      $display("[TB] FAIL ovf20_sat%0b: got valid=%b acc=%0d ovf=%b want 1 %0d 1", sat, out_valid20, $signed(out_acc20), out_ovf20, $signed(want20));
    end
    nVec++;
    if (out_valid !== 1'b1 || out_acc !== 32'd524288 || out_ovf !== 1'b0) begin
      nMiss++;
      $display("[TB] FAIL ovf32_sat%0b: got valid=%b acc=%0d ovf=%b want 1 524288 0", sat, out_valid, $signed(out_acc), out_ovf);
    end
    step();
    sat_en = 1'b0;
  endtask

  // A fresh vector after an overflowing one starts with a clean sticky flag.
  task automatic test_sticky_clear();
    driveBeat(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 1'b1);
    step();
    driveIdle();
    step();
    nVec++;
    if (out_valid20 !== 1'b1 || out_acc20 !== 20'd8 || out_ovf20 !== 1'b0) begin
      nMiss++;
      $display("[TB] FAIL sticky_clear: got valid=%b acc=%0d ovf=%b want 1 8 0", out_valid20, $signed(out_acc20), out_ovf20);
    end
    step();
  endtask

  // Three vectors against a blocked output: stall, hold, then drain in order.
  task automatic test_backpressure();
    out_ready = 1'b0;
    driveBeat(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 1'b1);
    step();
    driveBeat(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 1'b1);
    step();
    nVec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_acc !== 32'd10) begin
      nMiss++;
      $display("[TB] FAIL bp_stall: got ready=%b valid=%b acc=%0d want 0 1 10", in_ready, out_valid, $signed(out_acc));
    end
    driveBeat(pack4(-3, 0, 0, 0), pack4(5, 0, 0, 0), 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      nVec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_acc !== 32'd10) begin
        nMiss++;
        $display("[TB] FAIL bp_hold%0d: got ready=%b valid=%b acc=%0d want 0 1 10", k, in_ready, out_valid, $signed(out_acc));
      end
    end
    out_ready = 1'b1;
    #1;
    nVec++;
    if (in_ready !== 1'b1) begin
      nMiss++;
      $display("[TB] FAIL bp_release: got ready=%b want 1", in_ready);
    end
    step();
    driveIdle();
    nVec++;
    if (out_valid !== 1'b1 || out_acc !== 32'd8) begin
      nMiss++;
      $display("[TB] FAIL bp_second: got valid=%b acc=%0d want 1 8", out_valid, $signed(out_acc));
    end
    step();
    nVec++;
    if (out_valid !== 1'b1 || out_acc !== -32'sd15) begin
      nMiss++;
      $display("[TB] FAIL bp_third: got valid=%b acc=%0d want 1 -15", out_valid, $signed(out_acc));
    end
    step();
    nVec++;
    if (out_valid !== 1'b0) begin
      nMiss++;
      $display("[TB] FAIL bp_drain: got valid=%b want 0", out_valid);
    end
  endtask

  // Abort a 4-beat vector after beat 2; the next vector must be unaffected.
  task automatic test_clear();
    driveBeat(pack4(5, 5, 5, 5), pack4(5, 5, 5, 5), 1'b0);
    step();
    driveBeat(pack4(5, 5, 5, 5), pack4(5, 5, 5, 5), 1'b0);
    step();
    clear = 1'b1;
    driveBeat(pack4(5, 5, 5, 5), pack4(5, 5, 5, 5), 1'b1);
    #1;
    nVec++;
    if (in_ready !== 1'b1) begin
      nMiss++;
      $display("[TB] FAIL clear_ready: got ready=%b want 1", in_ready);
    end
    step();
    clear = 1'b0;
    driveBeat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b1);
    nVec++;
    if (out_valid !== 1'b0) begin
      nMiss++;
      $display("[TB] FAIL clear_noout: got valid=%b want 0", out_valid);
    end
    step();
    driveIdle();
    nVec++;
    if (out_valid !== 1'b0) begin
      nMiss++;
      $display("[TB] FAIL clear_noout2: got valid=%b want 0", out_valid);
    end
    step();
    nVec++;
    if (out_valid !== 1'b1 || out_acc !== 32'd4 || out_ovf !== 1'b0) begin
      nMiss++;
      $display("[TB] FAIL clear_next: got valid=%b acc=%0d ovf=%b want 1 4 0", out_valid, $signed(out_acc), out_ovf);
    end
    step();
  endtask

  // One-cycle reset with a pending result and a partial vector in flight.
  task automatic test_reset_mid();
    out_ready = 1'b0;
    driveBeat(pack4(2, 2, 2, 2), pack4(3, 3, 3, 3), 1'b1);
    step();
    driveBeat(pack4(7, 7, 7, 7), pack4(1, 1, 1, 1), 1'b0);
    step();
    driveIdle();
    nVec++;
    if (out_valid !== 1'b1 || out_acc !== 32'd24) begin
      nMiss++;
      $display("[TB] FAIL rmid_pending: got valid=%b acc=%0d want 1 24", out_valid, $signed(out_acc));
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    nVec++;
    if (out_valid !== 1'b0 || out_acc !== 32'd0 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
      nMiss++;
      $display("[TB] FAIL rmid_reset: got valid=%b acc=%0d ovf=%b ready=%b want 0 0 0 1", out_valid, $signed(out_acc), out_ovf, in_ready);
    end
    out_ready = 1'b1;
    driveBeat(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 1'b1);
    step();
    driveIdle();
    step();
    nVec++;
    if (out_valid !== 1'b1 || out_acc !== 32'd10 || out_ovf !== 1'b0) begin
      nMiss++;
      $display("[TB] FAIL rmid_next: got valid=%b acc=%0d ovf=%b want 1 10 0", out_valid, $signed(out_acc), out_ovf);
    end
    step();
  endtask

  // Scenario sequence and summary.
  initial begin
    nVec      = 0;
    nMiss     = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    sat_en    = 1'b0;
    out_ready = 1'b1;
    driveIdle();
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow(1'b1);
    test_overflow(1'b0);
    test_sticky_clear();
    test_backpressure();
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
